// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler: game FSM for the lamp/button reaction game.
// Lights one lamp at a time on an LFSR-chosen lane, scores hits on the matching
// active-low button, counts timeouts as misses and ends the round at MISS_LIMIT.
// Optional feature macro: SPEEDUP_EN (shrinks the lit window as score grows).
// Ports:
//   clk, reset        clock, async active-high reset
//   start             level; starts a game from IDLE or OVER
//   btn_n[LANES]      raw active-low buttons (asynchronous to clk)
//   lamp[LANES]       one-hot (or zero) lamp drive
//   ingame, game_over round status for the display
//   score, miss       hit / miss counters
//   hit_pulse         one-cycle strobe per scored hit
//   miss_pulse        one-cycle strobe per timeout
`timescale 1ns/1ps
module mole_round_scheduler #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned ON_CYCLES  = 50_000_000,
    parameter int unsigned GAP_CYCLES = 100_000_000,
    parameter int unsigned MISS_LIMIT = 10,
    parameter int unsigned SCORE_W    = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned SPEED_STEP = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LANES-1:0]   btn_n,
    output logic [LANES-1:0]   lamp,
    output logic               ingame,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         miss,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam int unsigned LANE_W  = $clog2(LANES);
    localparam int unsigned CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHOW, S_OVER} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, show_last;
    logic [LANE_W-1:0]  lane_q, lane_d, prev_lane_q, prev_lane_d, cand;
    logic [SCORE_W-1:0] score_d;
    logic [7:0]         miss_d;
    logic [LANES-1:0]   lamp_d;
    logic               hit_d, miss_p_d;
    logic [15:0]        lfsr_q;
    logic [LANES-1:0]   sync1_q, sync2_q, hist_q, press;
    logic               gap_done;

    assign cand     = lfsr_q[LANE_W-1:0];
    assign press    = hist_q & ~sync2_q;
    assign gap_done = (state_q == S_GAP) && (cnt_q == CNT_W'(GAP_CYCLES - 1));

`ifdef SPEEDUP_EN
    // Lit window is latched when the lamp lights and never shorter than a quarter.
    localparam longint unsigned WIN_FLOOR = (ON_CYCLES / 4 > 0) ? longint'(ON_CYCLES / 4) : 64'd1;
    logic [CNT_W:0] win_q, win_d;
    logic [63:0]    shrink;

    assign shrink    = 64'(score) * 64'(SPEED_STEP);
    assign show_last = CNT_W'(win_q - (CNT_W+1)'(1));

    always_comb begin
        win_d = win_q;
        if (gap_done) begin
            if (shrink + WIN_FLOOR >= 64'(ON_CYCLES))
                win_d = (CNT_W+1)'(WIN_FLOOR);
            else
                win_d = (CNT_W+1)'(64'(ON_CYCLES) - shrink);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) win_q <= (CNT_W+1)'(ON_CYCLES);
        else       win_q <= win_d;
    end
`else
    assign show_last = CNT_W'(ON_CYCLES - 1);
`endif

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        prev_lane_d = prev_lane_q;
        score_d     = score;
        miss_d      = miss;
        hit_d       = 1'b0;
        miss_p_d    = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_GAP;
                    score_d = '0;
                    miss_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    // Never repeat the previous lane.
                    lane_d      = (cand == prev_lane_q) ? cand + LANE_W'(1) : cand;
                    prev_lane_d = lane_d;
                    state_d     = S_SHOW;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHOW: begin
                // A hit takes priority over a timeout in the same cycle.
                if (press[lane_q]) begin
                    score_d = (&score) ? score : score + SCORE_W'(1);
                    hit_d   = 1'b1;
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == show_last) begin
                    miss_d   = miss + 8'd1;
                    miss_p_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = (miss_d == 8'(MISS_LIMIT)) ? S_OVER : S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        lamp_d = (state_d == S_SHOW) ? (LANES'(1) << lane_d) : '0;
    end

    // State, counters, synchroniser, LFSR and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lane_q      <= '0;
            prev_lane_q <= '0;
            lfsr_q      <= LFSR_SEED;
            sync1_q     <= '1;
            sync2_q     <= '1;
            hist_q      <= '1;
            lamp        <= '0;
            ingame      <= 1'b0;
            game_over   <= 1'b0;
            score       <= '0;
            miss        <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            prev_lane_q <= prev_lane_d;
            lfsr_q      <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            lamp        <= lamp_d;
            ingame      <= (state_d == S_GAP) || (state_d == S_SHOW);
            game_over   <= (state_d == S_OVER);
            score       <= score_d;
            miss        <= miss_d;
            hit_pulse   <= hit_d;
            miss_pulse  <= miss_p_d;
        end
    end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Bench for mole_round_scheduler: directed game scenarios plus random play,
// compared every cycle against a cycle-level game model.
`timescale 1ns/1ps
module tb_mole_round_scheduler;

    localparam int unsigned LANES = 4;
    localparam int unsigned ON    = 8;
    localparam int unsigned GAP   = 4;
    localparam int unsigned MLIM  = 3;
    localparam int unsigned SW    = 3;
    localparam int unsigned STEP  = 2;
    localparam int          SMAX  = (1 << SW) - 1;
    localparam logic [15:0] SEED  = 16'hACE1;

    localparam int P_IDLE = 0, P_GAP = 1, P_SHOW = 2, P_OVER = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LANES-1:0] btn_n = '1;
    logic [LANES-1:0] lamp;
    logic             ingame, game_over, hit_pulse, miss_pulse;
    logic [SW-1:0]    score;
    logic [7:0]       miss;

    always #5 clk = ~clk;

    mole_round_scheduler #(
        .LANES(LANES), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .MISS_LIMIT(MLIM),
        .SCORE_W(SW), .LFSR_SEED(SEED), .SPEED_STEP(STEP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .btn_n(btn_n),
        .lamp(lamp), .ingame(ingame), .game_over(game_over),
        .score(score), .miss(miss), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    int n_pass = 0;
    int n_total = 0;

    // Game model state.
    int               m_phase = P_IDLE, m_t = 0, m_lane = 0, m_prev = 0;
    int               m_score = 0, m_miss = 0;
    bit               m_hit = 0, m_missp = 0;
    logic [15:0]      m_lfsr = SEED;
    logic [LANES-1:0] dl0 = '1, dl1 = '1, dl2 = '1;

    // Observation-side trackers.
    int               dark_cnt = 0, lit_cnt = 0, last_lane = 0, lamps_seen = 0, hold = 0;
    logic [LANES-1:0] prev_lamp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_step();
        logic [LANES-1:0] press;
        logic [15:0]      cur;
        int               c;
        if (reset) begin
            m_phase = P_IDLE; m_t = 0; m_lane = 0; m_prev = 0;
            m_score = 0; m_miss = 0; m_hit = 0; m_missp = 0;
            m_lfsr = SEED; dl0 = '1; dl1 = '1; dl2 = '1;
            return;
        end
        press  = dl2 & ~dl1;
        cur    = m_lfsr;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        dl2 = dl1; dl1 = dl0; dl0 = btn_n;
        m_hit = 0; m_missp = 0;
        case (m_phase)
            P_IDLE, P_OVER: if (start) begin
                m_phase = P_GAP; m_score = 0; m_miss = 0; m_t = 0;
            end
            P_GAP: if (m_t == GAP - 1) begin
                c = int'(cur % LANES);
                if (c == m_prev) c = (c + 1) % LANES;
                m_lane = c; m_prev = c; m_phase = P_SHOW; m_t = 0;
            end else m_t++;
            default: begin
                if (press[m_lane]) begin
                    if (m_score < SMAX) m_score++;
                    m_hit = 1; m_phase = P_GAP; m_t = 0;
                end else if (m_t == ON - 1) begin
                    m_miss++; m_missp = 1; m_t = 0;
                    m_phase = (m_miss == MLIM) ? P_OVER : P_GAP;
                end else m_t++;
            end
        endcase
    endtask

    task automatic check_all();
        logic [LANES-1:0] el;
        int               idx;
        el = (m_phase == P_SHOW) ? (LANES'(1) << m_lane) : '0;
        check("lamp", 32'(lamp), 32'(el));
        check("ingame", 32'(ingame), 32'(m_phase == P_GAP || m_phase == P_SHOW));
        check("game_over", 32'(game_over), 32'(m_phase == P_OVER));
        check("score", 32'(score), 32'(m_score));
        check("miss", 32'(miss), 32'(m_miss));
        check("hit_pulse", 32'(hit_pulse), 32'(m_hit));
        check("miss_pulse", 32'(miss_pulse), 32'(m_missp));
        check("lamp_onehot0", 32'($onehot0(lamp)), 32'd1);
        if (reset) begin
            dark_cnt = 0; lit_cnt = 0; last_lane = 0; prev_lamp = '0;
            return;
        end
        if (lamp != '0) begin
            if (prev_lamp == '0) begin
                idx = 0;
                for (int i = 0; i < LANES; i++) if (lamp[i]) idx = i;
                check("gap_len", 32'(dark_cnt), 32'(GAP));
                check("lane_repeat", 32'(idx != last_lane), 32'd1);
                last_lane = idx; lit_cnt = 0; lamps_seen++;
            end
            lit_cnt++; dark_cnt = 0;
        end else begin
            if (prev_lamp != '0 && miss_pulse) check("on_len", 32'(lit_cnt), 32'(ON));
            dark_cnt = ingame ? dark_cnt + 1 : 0;
        end
        prev_lamp = lamp;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_phase(input int target, input int budget, input string tag);
        int n = 0;
        while (m_phase != target && n < budget) begin tick(); n++; end
        check(tag, 32'(m_phase), 32'(target));
    endtask

    task automatic press_lane(input int l);
        btn_n = ~(LANES'(1) << l);
    endtask

    task automatic rand_tick();
        int l;
        if (hold > 0) begin
            hold--;
            if (hold == 0) btn_n = '1;
        end else if ($urandom_range(0, 99) < 30) begin
            l = (m_phase == P_SHOW && $urandom_range(0, 2) != 0) ? m_lane
                                                                : int'($urandom_range(0, LANES - 1));
            press_lane(l);
            hold = int'($urandom_range(1, 4));
        end
        if (m_phase == P_IDLE || m_phase == P_OVER) start = ($urandom_range(0, 3) == 0);
        else start = $urandom_range(0, 1) != 0;
        tick();
    endtask

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // No presses: three timeouts end the round.
        start = 1'b1; tick(); start = 1'b0;
        wait_phase(P_OVER, 200, "t1_reach_over");
        check("t1_miss", 32'(miss), 32'd3);
        check("t1_ingame", 32'(ingame), 32'd0);
        check("t1_game_over", 32'(game_over), 32'd1);

        // Hit on the lit lane.
        start = 1'b1; tick(); start = 1'b0;
        wait_phase(P_SHOW, 50, "t2_reach_show");
        press_lane(m_lane);
        repeat (3) tick();
        check("t2_score", 32'(score), 32'd1);
        check("t2_hit_pulse", 32'(hit_pulse), 32'd1);
        check("t2_lamp_off", 32'(lamp), 32'd0);
        check("t2_miss", 32'(miss), 32'd0);
        repeat (2) tick();
        btn_n = '1;

        // Press on a non-lit lane is ignored; timeout still counts.
        wait_phase(P_SHOW, 50, "t3_reach_show");
        press_lane((m_lane + 1) % LANES);
        repeat (5) tick();
        btn_n = '1;
        check("t3_score", 32'(score), 32'd1);
        check("t3_lamp_on", 32'(lamp != '0), 32'd1);
        wait_phase(P_GAP, 50, "t3_timeout");
        check("t3_miss", 32'(miss), 32'd1);

        // Hit landing on the final lit cycle wins over the timeout.
        wait_phase(P_SHOW, 50, "t4_reach_show");
        for (int n = 0; n < int'(ON) && m_t != 5; n++) tick();
        press_lane(m_lane);
        repeat (3) tick();
        check("t4_score", 32'(score), 32'd2);
        check("t4_miss", 32'(miss), 32'd1);
        check("t4_miss_pulse", 32'(miss_pulse), 32'd0);
        check("t4_hit_pulse", 32'(hit_pulse), 32'd1);
        btn_n = '1;

        // Reset mid-SHOW drops the lamp at once.
        wait_phase(P_SHOW, 50, "t5_reach_show");
        tick();
        check("t5_score_before", 32'(score), 32'd2);
        reset = 1'b1;
        #1;
        check("t5_lamp_async", 32'(lamp), 32'd0);
        check("t5_score_async", 32'(score), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_phase(P_OVER, 200, "t5_reach_over");
        start = 1'b1; tick(); start = 1'b0;
        check("t5_restart_ingame", 32'(ingame), 32'd1);
        check("t5_restart_score", 32'(score), 32'd0);
        check("t5_restart_miss", 32'(miss), 32'd0);

        // Score saturates at all-ones.
        for (int k = 0; k < SMAX + 2; k++) begin
            wait_phase(P_SHOW, 50, "t7_reach_show");
            press_lane(m_lane);
            repeat (4) tick();
            btn_n = '1;
        end
        check("t7_score_sat", 32'(score), 32'(SMAX));

        // Random play across many lamps and rounds.
        lamps_seen = 0;
        for (int n = 0; n < 4000 && lamps_seen < 60; n++) rand_tick();
        check("t6_lamps_seen", 32'(lamps_seen >= 60), 32'd1);
        btn_n = '1; start = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
